// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: 4-digit common-anode scanner around one shared hex decoder.
// Optional build macro: SEVSEG_LZ_BLANK_EN (leading-zero suppression).

module hex_to_7seg (
   input  logic [3:0] i_nibble,
   output logic [7:0] o_seg
);
   // active-low a..g in [7:1], dp (bit 0) always off
   always_comb begin
      o_seg = 8'hFF;
      unique case (i_nibble)
         4'h0: o_seg = 8'h03;
         4'h1: o_seg = 8'h9F;
         4'h2: o_seg = 8'h25;
         4'h3: o_seg = 8'h0D;
         4'h4: o_seg = 8'h99;
         4'h5: o_seg = 8'h49;
         4'h6: o_seg = 8'h41;
         4'h7: o_seg = 8'h1F;
         4'h8: o_seg = 8'h01;
         4'h9: o_seg = 8'h09;
         4'hA: o_seg = 8'h11;
         4'hB: o_seg = 8'hC1;
         4'hC: o_seg = 8'h63;
         4'hD: o_seg = 8'h85;
         4'hE: o_seg = 8'h61;
         4'hF: o_seg = 8'h71;
      endcase
   end
endmodule

module seven_seg_scanner #(
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_Enable,
   input  logic [15:0] i_Value,
   input  logic        i_Load,
   input  logic [3:0]  i_DpMask,
   output logic [3:0]  o_DispSelect,
   output logic [7:0]  o_SevenSegValue,
   output logic        o_FrameDone
);
   localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] LAST_C  = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] BLANK_C = CW'(BLANK_CYCLES);

   logic [CW-1:0] r_cnt;
   logic [1:0]    r_idx;
   logic [15:0]   r_pend_val;
   logic [3:0]    r_pend_dp;
   logic          r_pend_flag;
   logic [15:0]   r_act_val;
   logic [3:0]    r_act_dp;

   logic          w_boundary;
   logic          w_copy;
   logic [15:0]   w_val;
   logic [3:0]    w_dp;
   logic [3:0]    w_nibble;
   logic [7:0]    w_seg;
   logic          w_lz;
   logic          w_blank;
   logic          w_last;

   assign w_boundary = i_Enable && (r_cnt == '0) && (r_idx == 2'd0);
   assign w_copy     = w_boundary && r_pend_flag;
   // the frame that starts on the boundary already shows the new contents
   assign w_val      = w_copy ? r_pend_val : r_act_val;
   assign w_dp       = w_copy ? r_pend_dp  : r_act_dp;
   assign w_nibble   = w_val[{r_idx, 2'b00} +: 4];
   assign w_last     = (r_idx == 2'd3) && (r_cnt == LAST_C);

   hex_to_7seg u_dec (
      .i_nibble (w_nibble),
      .o_seg    (w_seg)
   );

`ifdef SEVSEG_LZ_BLANK_EN
   // a digit is a leading zero when it and every higher nibble are zero
   always_comb begin
      w_lz = 1'b0;
      unique case (r_idx)
         2'd3:    w_lz = (w_val[15:12] == 4'h0)  && !w_dp[3];
         2'd2:    w_lz = (w_val[15:8]  == 8'h00) && !w_dp[2];
         2'd1:    w_lz = (w_val[15:4]  == 12'h0) && !w_dp[1];
         default: w_lz = 1'b0;
      endcase
   end
`else
   assign w_lz = 1'b0;
`endif

   assign w_blank = (r_cnt < BLANK_C) || w_lz;

   // slot counter and digit index, parked at frame start while disabled
   always_ff @(posedge i_clk) begin
      if (i_reset || !i_Enable) begin
         r_cnt <= '0;
         r_idx <= 2'd0;
      end else if (r_cnt == LAST_C) begin
         r_cnt <= '0;
         r_idx <= r_idx + 2'd1;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // pending buffer: last load wins, flag drops when consumed
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_pend_val  <= 16'h0;
         r_pend_dp   <= 4'h0;
         r_pend_flag <= 1'b0;
      end else begin
         if (w_copy) r_pend_flag <= 1'b0;
         if (i_Load) begin
            r_pend_val  <= i_Value;
            r_pend_dp   <= i_DpMask;
            r_pend_flag <= 1'b1;
         end
      end
   end

   // active buffer only changes on a frame boundary
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_act_val <= 16'h0;
         r_act_dp  <= 4'h0;
      end else if (w_copy) begin
         r_act_val <= r_pend_val;
         r_act_dp  <= r_pend_dp;
      end
   end

   // registered anode/segment drive and frame pulse
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_DispSelect    <= 4'hF;
         o_SevenSegValue <= 8'hFF;
         o_FrameDone     <= 1'b0;
      end else begin
         o_FrameDone <= i_Enable && w_last;
         if (!i_Enable || w_blank) begin
            o_DispSelect    <= 4'hF;
            o_SevenSegValue <= 8'hFF;
         end else begin
            o_DispSelect    <= ~(4'b0001 << r_idx);
            o_SevenSegValue <= {w_seg[7:1], w_seg[0] & ~w_dp[r_idx]};
         end
      end
   end
endmodule
